power_sequencer_ctrl: RTL and testbench
=======================================

POWER_SEQUENCER_CTRL -- requirements
Module: power_sequencer_ctrl

Interface
REQ-001 SHALL provide parameter NumConverters, default 4, number of sequenced rails, legal 1..8.
REQ-002 SHALL provide parameter PgoodTimeout, default 16'd1000, max clock cycles allowed for a rail's pgood after its enable, legal 1..65535.
REQ-003 SHALL provide parameter SeqDelay, default 16'd10, settle cycles between consecutive enable/disable steps, legal 1..65535.
REQ-004 clock  input  1  block clock; one clock domain, all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level request to power up; sampled in IDLE only.
REQ-007 stop  input  1  level request to power down; sampled in UP_WAIT, UP_DELAY, ON.
REQ-008 clear_fault  input  1  level; releases FAULT state.
REQ-009 pgood  input  NumConverters  per-rail power-good, synchronous to clock.
REQ-010 en  output  NumConverters  per-rail converter enable, registered.
REQ-011 busy  output  1  high in any state other than IDLE, ON, FAULT.
REQ-012 up_done  output  1  one-cycle pulse on entry to ON.
REQ-013 fault  output  1  high while in FAULT.
REQ-014 fault_idx  output  3  index of the rail that caused the latest fault; held until next fault or reset.

Function
REQ-015 SHALL implement states IDLE, UP_WAIT, UP_DELAY, ON, DOWN, FAULT with an internal rail index idx (3-bit) and 16-bit cycle counter cnt.
REQ-016 IDLE: en=0; start=1 -> UP_WAIT with idx=0, cnt=0; en[0] asserts in the cycle after start is sampled.
REQ-017 UP_WAIT: en[j]=1 for all j<=idx; cnt increments each cycle; pgood[idx]=1 -> UP_DELAY, cnt=0.
REQ-018 UP_WAIT timeout: pgood[idx]=0 with cnt==PgoodTimeout-1 -> FAULT, fault_idx=idx; the pgood check wins when both happen in the same cycle.
REQ-019 UP_DELAY: hold en; after SeqDelay cycles -> ON if idx==NumConverters-1, else idx+1 and UP_WAIT with cnt=0.
REQ-020 Rail-loss monitoring in UP_WAIT/UP_DELAY: any pgood[j]=0 with j<idx (UP_WAIT) or j<=idx (UP_DELAY) -> FAULT, fault_idx=lowest such j.
REQ-021 ON: en all ones (NumConverters bits); up_done pulses for exactly one cycle on entry; any pgood[j]=0 -> FAULT, fault_idx=lowest such j.
REQ-022 stop=1 in UP_WAIT/UP_DELAY/ON -> DOWN starting at current idx; en[idx] clears on DOWN entry, then after SeqDelay cycles en[idx-1] clears, repeating down to 0.
REQ-023 DOWN: after en[0] cleared and SeqDelay elapsed -> IDLE; pgood is not monitored in DOWN; start and stop are ignored.
REQ-024 Priority in the same cycle: fault condition > stop > normal progression.
REQ-025 FAULT: en=0 in the cycle after entry (all rails at once); fault=1; clear_fault=1 -> IDLE; start is ignored until the block has returned to IDLE.
REQ-026 cnt SHALL saturate at 16'hFFFF, never wrap; idx never exceeds NumConverters-1 and never underflows below 0.
REQ-027 SHALL assign outputs only from registers; no combinational path from inputs to en, fault, busy, or up_done.

Reset
REQ-028 reset=1 SHALL force, asynchronously: state=IDLE, en=0, busy=0, up_done=0, fault=0, fault_idx=0, idx=0, cnt=0.
REQ-029 Reset asserted mid-sequence (any state) SHALL drop all enables immediately, without reverse-order sequencing.
REQ-030 After reset deassertion the first start is honoured no earlier than the first rising clock edge.

Verification
REQ-031 N=4, Timeout=1000, Delay=10. Stimulus: start; pgood[i] rises 5 cycles after en[i]. Required: en goes 0001->0011->0111->1111, one step per 15 cycles; up_done pulses once; busy=0 in ON.
REQ-032 Same setup, pgood[2] never rises. Required: FAULT exactly 1000 cycles after en[2]; en=0 next cycle; fault=1; fault_idx=2; clear_fault -> IDLE.
REQ-033 ON, then pgood[1]=0 and pgood[3]=0 in the same cycle. Required: FAULT with fault_idx=1.
REQ-034 ON, then stop. Required: en goes 0111->0011->0001->0000 at 10-cycle spacing, then IDLE; start held high through DOWN does not restart the sequence.
REQ-035 stop and a pgood drop in the same cycle during UP_DELAY. Required: FAULT, not DOWN.
REQ-036 Reset pulse during UP_WAIT with idx=2. Required: en=0 immediately, all outputs at reset values, and a clean restart on the next start.

Source files
------------

// File: rtl/power_sequencer_ctrl_if.sv
// Control/status bundle between a power-up requester and power_sequencer_ctrl.
// The master drives requests and rail power-good; the slave drives enables and status.
interface power_sequencer_ctrl_if #(
  parameter int unsigned NumConverters = 4
);
  logic                     start;
  logic                     stop;
  logic                     clear_fault;
  logic [NumConverters-1:0] pgood;
  logic [NumConverters-1:0] en;
  logic                     busy;
  logic                     up_done;
  logic                     fault;
  logic [2:0]               fault_idx;

  modport master (
    output start, stop, clear_fault, pgood,
    input  en, busy, up_done, fault, fault_idx
  );

  modport slave (
    input  start, stop, clear_fault, pgood,
    output en, busy, up_done, fault, fault_idx
  );
endinterface

// File: rtl/power_sequencer_ctrl.sv
// Sequences converter enables up one rail at a time (waiting on pgood plus a settle delay),
// down in reverse order on stop, and drops every rail at once on a pgood fault or timeout.
module power_sequencer_ctrl #(
  parameter int unsigned NumConverters = 4,
  parameter logic [15:0] PgoodTimeout  = 16'd1000,
  parameter logic [15:0] SeqDelay      = 16'd10
) (
  input  logic clock,
  input  logic reset,
  power_sequencer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    UP_WAIT,
    UP_DELAY,
    ON,
    DOWN,
    FAULT
  } state_t;

  localparam logic [2:0] LastIdx = 3'(NumConverters - 1);

  state_t                   state, state_nxt;
  logic [2:0]               idx, idx_nxt;
  logic [15:0]              cnt, cnt_nxt, cnt_inc;
  logic [NumConverters-1:0] en_q, en_nxt;
  logic                     busy_q, up_done_q, fault_q;
  logic [2:0]               fault_idx_q, fault_idx_nxt;

  logic [NumConverters-1:0] loss_mask, lost;
  logic                     loss_vld;
  logic [2:0]               loss_idx;
  logic                     pg_cur;
  logic                     fault_go, down_go;
  logic [2:0]               fault_src;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Rails already brought up must stay good; the lowest failing rail is reported.
  always_comb begin
    loss_mask = '0;
    pg_cur    = 1'b0;
    loss_idx  = 3'd0;
    for (int j = 0; j < NumConverters; j++) begin
      case (state)
        UP_WAIT:  loss_mask[j] = (3'(j) < idx);
        UP_DELAY: loss_mask[j] = (3'(j) <= idx);
        ON:       loss_mask[j] = 1'b1;
        default:  loss_mask[j] = 1'b0;
      endcase
      if (3'(j) == idx) pg_cur = bus.pgood[j];
    end
    lost     = ~bus.pgood & loss_mask;
    loss_vld = |lost;
    for (int j = NumConverters - 1; j >= 0; j--) begin
      if (lost[j]) loss_idx = 3'(j);
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    en_nxt        = en_q;
    fault_idx_nxt = fault_idx_q;
    fault_go      = 1'b0;
    fault_src     = 3'd0;
    down_go       = 1'b0;

    case (state)
      IDLE: begin
        en_nxt = '0;
        if (bus.start) begin
          state_nxt = UP_WAIT;
          idx_nxt   = 3'd0;
          cnt_nxt   = 16'd0;
          en_nxt[0] = 1'b1;
        end
      end
      UP_WAIT: begin
        if (loss_vld) begin
          fault_go  = 1'b1;
          fault_src = loss_idx;
        end else if (!pg_cur && cnt == PgoodTimeout - 16'd1) begin
          fault_go  = 1'b1;
          fault_src = idx;
        end else if (bus.stop) begin
          down_go = 1'b1;
        end else if (pg_cur) begin
          state_nxt = UP_DELAY;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      UP_DELAY: begin
        if (loss_vld) begin
          fault_go  = 1'b1;
          fault_src = loss_idx;
        end else if (bus.stop) begin
          down_go = 1'b1;
        end else if (cnt == SeqDelay - 16'd1) begin
          cnt_nxt = 16'd0;
          if (idx == LastIdx) begin
            state_nxt = ON;
          end else begin
            state_nxt = UP_WAIT;
            idx_nxt   = idx + 3'd1;
            for (int j = 0; j < NumConverters; j++) begin
              if (3'(j) == idx + 3'd1) en_nxt[j] = 1'b1;
            end
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ON: begin
        en_nxt = '1;
        if (loss_vld) begin
          fault_go  = 1'b1;
          fault_src = loss_idx;
        end else if (bus.stop) begin
          down_go = 1'b1;
        end
      end
      DOWN: begin
        if (cnt == SeqDelay - 16'd1) begin
          cnt_nxt = 16'd0;
          if (idx == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx - 3'd1;
            for (int j = 0; j < NumConverters; j++) begin
              if (3'(j) == idx - 3'd1) en_nxt[j] = 1'b0;
            end
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      FAULT: begin
        en_nxt = '0;
        if (bus.clear_fault) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          cnt_nxt   = 16'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        en_nxt    = '0;
      end
    endcase

    // Entering FAULT drops every rail together; DOWN drops only the current rail.
    if (fault_go) begin
      state_nxt     = FAULT;
      cnt_nxt       = 16'd0;
      en_nxt        = '0;
      fault_idx_nxt = fault_src;
    end else if (down_go) begin
      state_nxt = DOWN;
      cnt_nxt   = 16'd0;
      for (int j = 0; j < NumConverters; j++) begin
        if (3'(j) == idx) en_nxt[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cnt         <= 16'd0;
      en_q        <= '0;
      busy_q      <= 1'b0;
      up_done_q   <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= 3'd0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      en_q        <= en_nxt;
      busy_q      <= !(state_nxt inside {IDLE, ON, FAULT});
      up_done_q   <= (state_nxt == ON) && (state != ON);
      fault_q     <= (state_nxt == FAULT);
      fault_idx_q <= fault_idx_nxt;
    end
  end

  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.up_done   = up_done_q;
  assign bus.fault     = fault_q;
  assign bus.fault_idx = fault_idx_q;

endmodule

// File: tb/tb_power_sequencer_ctrl.sv
// Directed bench for power_sequencer_ctrl: 4 rails, timeout 1000, settle delay 10.
// A rail model raises pgood[i] 5 cycles after en[i] unless that rail is masked off.
module tb_power_sequencer_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  power_sequencer_ctrl_if #(.NumConverters(4)) bus ();

  power_sequencer_ctrl #(
    .NumConverters(4),
    .PgoodTimeout (16'd1000),
    .SeqDelay     (16'd10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         upd_cnt  = 0;
  int         t;
  logic [3:0] kill     = 4'b0000;
  int         age[4];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (bus.up_done === 1'b1) upd_cnt++;

  // Rail model: pgood is sampled by the DUT on the 5th rising edge after en rises.
  always @(posedge clock) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (bus.en[i] === 1'b1) age[i] = (age[i] < 100) ? age[i] + 1 : age[i];
      else                    age[i] = 0;
      bus.pgood[i] = (age[i] >= 5) && !kill[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_en(input logic [3:0] v, input int budget, input string tag);
    int k = 0;
    while (bus.en !== v && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, 32'(bus.en), 32'(v));
  endtask

  task automatic wait_fault(input int budget, input string tag);
    int k = 0;
    while (bus.fault !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, 32'(bus.fault), 32'd1);
  endtask

  task automatic wait_not_busy(input int budget, input string tag);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic clear_and_check(input string tag);
    bus.clear_fault = 1'b1;
    @(negedge clock);
    bus.clear_fault = 1'b0;
    check({tag, "_fault_cleared"}, 32'(bus.fault), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear_fault = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_en",      32'(bus.en),        32'd0);
    check("rst_busy",    32'(bus.busy),      32'd0);
    check("rst_up_done", 32'(bus.up_done),   32'd0);
    check("rst_fault",   32'(bus.fault),     32'd0);
    check("rst_fidx",    32'(bus.fault_idx), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Normal power-up: one rail every 15 cycles, single up_done, idle-like busy in ON.
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("up_en0",   32'(bus.en),   32'h1);
    check("up_busy",  32'(bus.busy), 32'd1);
    t = cyc;
    wait_en(4'b0011, 40, "up_en1");
    check("up_step1", 32'(cyc - t), 32'd15);
    t = cyc;
    wait_en(4'b0111, 40, "up_en2");
    check("up_step2", 32'(cyc - t), 32'd15);
    t = cyc;
    wait_en(4'b1111, 40, "up_en3");
    check("up_step3", 32'(cyc - t), 32'd15);
    wait_not_busy(40, "up_on_busy");
    repeat (5) @(negedge clock);
    check("up_done_once", 32'(upd_cnt), 32'd1);
    check("up_on_en",     32'(bus.en),  32'hF);
    check("up_on_fault",  32'(bus.fault), 32'd0);

    // Two rails lost together while ON: the lower index is reported.
    kill = 4'b1010;
    wait_fault(10, "loss_fault");
    check("loss_fidx", 32'(bus.fault_idx), 32'd1);
    check("loss_en",   32'(bus.en),        32'd0);
    kill = 4'b0000;
    clear_and_check("loss");

    // Power-down from ON with start held high the whole way.
    pulse_start();
    wait_en(4'b1111, 80, "down_up");
    wait_not_busy(40, "down_on");
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    check("down_en3", 32'(bus.en), 32'h7);
    t = cyc;
    wait_en(4'b0011, 20, "down_en2");
    check("down_step2", 32'(cyc - t), 32'd10);
    t = cyc;
    wait_en(4'b0001, 20, "down_en1");
    check("down_step1", 32'(cyc - t), 32'd10);
    t = cyc;
    wait_en(4'b0000, 20, "down_en0");
    check("down_step0", 32'(cyc - t), 32'd10);
    check("down_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (10) @(negedge clock);
    check("down_idle",    32'(bus.busy), 32'd0);
    check("down_no_rest", 32'(bus.en),   32'd0);
    check("down_updone",  32'(upd_cnt),  32'd2);

    // stop and a rail drop sampled on the same edge during UP_DELAY: fault wins.
    pulse_start();
    wait_en(4'b0011, 40, "prio_en1");
    begin
      int k = 0;
      while (bus.pgood[1] !== 1'b1 && k < 10) begin
        @(negedge clock);
        k++;
      end
    end
    check("prio_pg1", 32'(bus.pgood[1]), 32'd1);
    @(negedge clock);
    kill = 4'b0001;
    @(negedge clock);
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    check("prio_fault", 32'(bus.fault),     32'd1);
    check("prio_fidx",  32'(bus.fault_idx), 32'd0);
    check("prio_en",    32'(bus.en),        32'd0);
    kill = 4'b0000;
    clear_and_check("prio");

    // Rail 2 never reports good: timeout exactly 1000 cycles after its enable.
    kill = 4'b0100;
    pulse_start();
    wait_en(4'b0111, 60, "tmo_en2");
    t = cyc;
    wait_fault(1100, "tmo_fault");
    check("tmo_cycles", 32'(cyc - t),       32'd1000);
    check("tmo_fidx",   32'(bus.fault_idx), 32'd2);
    check("tmo_en",     32'(bus.en),        32'd0);
    @(negedge clock);
    check("tmo_en_next",    32'(bus.en),    32'd0);
    check("tmo_fault_hold", 32'(bus.fault), 32'd1);
    check("tmo_busy",       32'(bus.busy),  32'd0);
    kill = 4'b0000;
    clear_and_check("tmo");

    // Asynchronous reset while waiting on rail 2, then a clean restart.
    pulse_start();
    wait_en(4'b0111, 60, "arst_en2");
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_en",      32'(bus.en),        32'd0);
    check("arst_busy",    32'(bus.busy),      32'd0);
    check("arst_up_done", 32'(bus.up_done),   32'd0);
    check("arst_fault",   32'(bus.fault),     32'd0);
    check("arst_fidx",    32'(bus.fault_idx), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("arst_still_idle", 32'(bus.en), 32'd0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("arst_re_en0", 32'(bus.en), 32'h1);
    wait_en(4'b1111, 80, "arst_re_up");
    wait_not_busy(40, "arst_re_on");
    repeat (3) @(negedge clock);
    check("arst_re_updone", 32'(upd_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
